// File: rtl/net_demux_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | net_demux_router: registered 1-to-NUM_CH demux with per-channel buffers, |
// | broadcast, saturating delivery/drop statistics.          Rev 1.0         |
// +--------------------------------------------------------------------------+
module net_demux_router #(
    parameter int DATA_W = 4,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*CNT_W-1:0]  ch_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     drop_pulse
);

    localparam int c_SEL_SPAN = 2 ** SEL_W;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    logic [NUM_CH-1:0]     w_space;
    logic [NUM_CH-1:0]     w_load;
    logic [c_SEL_SPAN-1:0] w_space_pad;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_drop;

    logic [CNT_W-1:0]      r_drop_cnt;
    logic                  r_drop_pulse;

    assign w_in_range  = (32'(in_sel) < NUM_CH);
    // Zero-extended so any in_sel value indexes a real bit.
    assign w_space_pad = c_SEL_SPAN'(w_space);

    always_comb begin
        in_ready = 1'b0;
        if (enable) begin
            if (in_bcast) begin
                in_ready = &w_space;
            end else if (w_in_range) begin
                in_ready = w_space_pad[in_sel];
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_drop   = w_accept & ~in_bcast & ~w_in_range;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam logic [SEL_W-1:0] c_IDX = SEL_W'(c);

            state_t            r_state;
            logic [DATA_W-1:0] r_data;
            logic [CNT_W-1:0]  r_cnt;
            logic              w_drain;

            assign w_space[c] = (r_state == ST_EMPTY) | out_ready[c];
            assign w_load[c]  = w_accept & (in_bcast | (w_in_range & (in_sel == c_IDX)));
            assign w_drain    = (r_state == ST_FULL) & out_ready[c];

            // Buffer data is cleared on drain so an empty channel reads as zero.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= ST_EMPTY;
                    r_data  <= '0;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_load[c]) begin
                                r_state <= ST_FULL;
                                r_data  <= in_data;
                            end
                        end
                        ST_FULL: begin
                            if (w_load[c]) begin
                                r_data <= in_data;
                            end else if (w_drain) begin
                                r_state <= ST_EMPTY;
                                r_data  <= '0;
                            end
                        end
                        default: begin
                            r_state <= ST_EMPTY;
                            r_data  <= '0;
                        end
                    endcase
                    if (w_drain && (r_cnt != {CNT_W{1'b1}})) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign out_valid[c]                   = (r_state == ST_FULL);
            assign out_data[c*DATA_W +: DATA_W]   = r_data;
            assign ch_count[c*CNT_W +: CNT_W]     = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt   <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign drop_count = r_drop_cnt;
    assign drop_pulse = r_drop_pulse;

endmodule
`default_nettype wire

// File: tb/tb_net_demux_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_net_demux_router: directed + random checks against a queue-free model. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_net_demux_router;

    localparam int NCH  = 3;
    localparam int DW   = 4;
    localparam int SW   = 2;
    localparam int CW   = 3;
    localparam int CMAX = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic [SW-1:0]     in_sel = '0;
    logic              in_bcast = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready = '0;
    logic [NCH*CW-1:0] ch_count;
    logic [CW-1:0]     drop_count;
    logic              drop_pulse;

    int total = 0;
    int bad   = 0;

    // Reference model: what each channel holds and how much it has counted.
    bit       m_full[NCH];
    bit [3:0] m_data[NCH];
    int       m_cnt[NCH];
    int       m_drop;
    bit       m_pulse;

    net_demux_router #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .ch_count(ch_count), .drop_count(drop_count),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_full[c] = 0; m_data[c] = 0; m_cnt[c] = 0;
        end
        m_drop = 0; m_pulse = 0;
    endtask

    function automatic bit model_ready();
        bit all_space = 1;
        if (!enable) return 0;
        for (int c = 0; c < NCH; c++)
            if (m_full[c] && !out_ready[c]) all_space = 0;
        if (in_bcast) return all_space;
        if (int'(in_sel) < NCH) return !m_full[in_sel] || out_ready[in_sel];
        return 1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [NCH*DW-1:0] e_data = '0;
        logic [NCH-1:0]    e_valid = '0;
        logic [NCH*CW-1:0] e_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            e_valid[c] = m_full[c];
            e_data[c*DW +: DW] = m_full[c] ? m_data[c] : 4'h0;
            e_cnt[c*CW +: CW] = CW'(m_cnt[c]);
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
        chk({tag, ".out_data"}, 64'(out_data), 64'(e_data));
        chk({tag, ".ch_count"}, 64'(ch_count), 64'(e_cnt));
        chk({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
        chk({tag, ".drop_pulse"}, 64'(drop_pulse), 64'(m_pulse));
    endtask

    // Apply one cycle of inputs, check in_ready, advance the model and check outputs.
    task automatic step(input string tag, input bit en, input bit v, input int sel,
                        input bit bc, input int d, input logic [NCH-1:0] rdy);
        bit acc;
        enable = en; in_valid = v; in_sel = SW'(sel); in_bcast = bc;
        in_data = DW'(d); out_ready = rdy;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(model_ready()));
        acc = v && model_ready();
        for (int c = 0; c < NCH; c++) begin
            if (m_full[c] && rdy[c]) begin
                m_cnt[c] = (m_cnt[c] + 1 > CMAX) ? CMAX : m_cnt[c] + 1;
                m_full[c] = 0;
                m_data[c] = 0;
            end
            if (acc && (bc || sel == c)) begin
                m_full[c] = 1;
                m_data[c] = 4'(d);
            end
        end
        m_pulse = acc && !bc && sel >= NCH;
        if (m_pulse) m_drop = (m_drop + 1 > CMAX) ? CMAX : m_drop + 1;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // Targeted word to channel 2, visible the cycle after acceptance.
        step("tgt", 1, 1, 2, 0, 'hA, 3'b111);
        chk("tgt.valid_lit", 64'(out_valid), 64'(3'b100));
        chk("tgt.slice2_lit", 64'(out_data[2*DW +: DW]), 64'hA);
        step("tgt_drain", 1, 0, 0, 0, 0, 3'b111);
        chk("tgt.cnt2_lit", 64'(ch_count[2*CW +: CW]), 64'd1);

        // Backpressure on channel 1 holds the first word and stalls the second.
        step("bp1", 1, 1, 1, 0, 'h3, 3'b101);
        step("bp2", 1, 1, 1, 0, 'h5, 3'b101);
        chk("bp.held_lit", 64'(out_data[1*DW +: DW]), 64'h3);
        step("bp3", 1, 1, 1, 0, 'h5, 3'b111);
        chk("bp.new_lit", 64'(out_data[1*DW +: DW]), 64'h5);

        // Fill all, then broadcast blocked by one stalled channel.
        step("fill0", 1, 1, 0, 0, 'h1, 3'b000);
        step("fill2", 1, 1, 2, 0, 'h2, 3'b000);
        step("bc_blk", 1, 1, 0, 1, 'hF, 3'b011);
        step("bc_go", 1, 1, 3, 1, 'hF, 3'b111);
        chk("bc.valid_lit", 64'(out_valid), 64'(3'b111));
        chk("bc.data_lit", 64'(out_data), 64'hFFF);

        // Out-of-range select is accepted and dropped.
        step("drop", 1, 1, 3, 0, 'h9, 3'b111);
        chk("drop.pulse_lit", 64'(drop_pulse), 64'd1);
        step("drop_after", 1, 0, 3, 0, 'h9, 3'b111);
        chk("drop.pulse_clr_lit", 64'(drop_pulse), 64'd0);

        // Saturation on channel 0.
        for (int i = 0; i < 10; i++) step("sat", 1, 1, 0, 0, i, 3'b111);
        step("sat_end", 1, 0, 0, 0, 0, 3'b111);
        chk("sat.cnt0_lit", 64'(ch_count[0 +: CW]), 64'(CMAX));

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step("rnd", ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 15), NCH'($urandom_range(0, 7)));

        // Asynchronous reset mid-cycle clears buffers before the next edge.
        step("pre_rst", 1, 1, 0, 0, 'h6, 3'b000);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.out_data", 64'(out_data), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("arst_hold");
        reset = 1'b0;

        // Disabled: never ready, whatever in_valid says.
        step("dis_v1", 0, 1, 0, 0, 'h7, 3'b111);
        step("dis_v0", 0, 0, 3, 1, 'h7, 3'b111);
        chk("dis.ready_lit", 64'(in_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/net_demux_router.md
Name: net_demux_router

Overview:
- Parametrised, registered successor to the combinational 1-to-4 internet demux.
- Routes one upstream data word per cycle to one of NUM_CH downstream channels, or to all of them in broadcast mode.
- Each channel has a one-entry output buffer with a valid/ready handshake.
- Keeps saturating per-channel delivery counters and a drop counter for out-of-range selects.
- Sits between the upstream internet mux and the consumer blocks (library, fire dept, school, ribs, ...).

Parameters:
- DATA_W, 4, width of a data word.
- NUM_CH, 4, number of output channels; legal range 2..16.
- SEL_W, 2, width of in_sel; must satisfy 2**SEL_W >= NUM_CH.
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global accept enable.
- in_data  input  DATA_W  upstream word.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  when 1, in_sel is ignored and the word goes to every channel.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- out_valid  output  NUM_CH  per-channel valid.
- out_ready  input  NUM_CH  per-channel downstream ready.
- ch_count  output  NUM_CH*CNT_W  words delivered per channel, saturating; channel c at [c*CNT_W +: CNT_W].
- drop_count  output  CNT_W  words dropped for an out-of-range in_sel, saturating.
- drop_pulse  output  1  registered one-cycle pulse, asserted the cycle after each drop.

Behaviour:
- Reset (async, active-high): all buffers EMPTY, buffer data 0, out_valid 0, out_data 0, ch_count 0, drop_count 0, drop_pulse 0.
- Per-channel FSM, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without a simultaneous load.
  - FULL stays FULL on simultaneous drain and load; the buffer takes the new data.
  - FULL stays FULL while out_ready=0; data is held stable.
- out_valid[c] = 1 in FULL. out_data slice c = buffer data in FULL, else 0 (unselected channels read as zero).
- space[c] = (state EMPTY) or out_ready[c]. Same-cycle drain frees the slot, so full throughput of 1 word/cycle per channel is achieved.
- in_ready is combinational:
  - enable=0: 0.
  - in_bcast=1: AND of space[c] over all c.
  - in_sel < NUM_CH: space[in_sel].
  - in_sel >= NUM_CH: 1 (accept and drop).
- in_ready may depend combinationally on out_ready. It must not depend on in_valid.
- Accept = in_valid and in_ready.
  - Targeted: load channel in_sel.
  - Broadcast: load every channel in the same cycle.
  - Out-of-range: no load; drop_count increments; drop_pulse is 1 on the next cycle.
- Latency: an accepted word appears on out_valid/out_data on the rising edge following acceptance (1 cycle).
- Drain on channel c = out_valid[c] and out_ready[c]. ch_count[c] increments per drain.
- Counters saturate at all-ones and never wrap.
- enable=0: no new accepts. Buffered words still drain normally.
- in_bcast=1 overrides any in_sel value, including out-of-range; no drop is counted.
- Reset asserted mid-transfer: buffered words are discarded immediately (async). No handshake completes during reset.
- Upstream words are only consumed on accept; a word not accepted is not counted, routed or dropped.

Test Plan:
- Reset, enable=1, in_data=4'hA, in_sel=2, in_valid=1 one cycle, out_ready=4'b1111 -> next cycle out_valid=4'b0100, slice 2=4'hA, all other slices 0; ch_count[2]=1 after drain.
- Channel 1 with out_ready[1]=0: send 4'h3 then 4'h5 to sel=1 -> second word has in_ready=0 and is held. Raise out_ready[1] -> 4'h3 drains, 4'h5 is accepted the same cycle and appears next cycle.
- in_bcast=1, in_data=4'hF, out_ready=4'b1011 with all buffers FULL -> in_ready=0. Set out_ready=4'b1111 -> accepted; next cycle out_valid=4'b1111, all slices 4'hF.
- NUM_CH=3, SEL_W=2, in_sel=3, in_valid=1 -> in_ready=1, no out_valid, drop_count=1, drop_pulse high exactly one cycle.
- CNT_W=2, stream 5 words to channel 0 with out_ready=1 -> ch_count[0] sequence 1,2,3,3,3.
- Load channel 0 with out_ready=0, assert reset mid-cycle -> out_valid=0 and out_data=0 immediately, before the next clk edge. enable=0 after reset -> in_ready=0 regardless of in_valid.
